// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment types and hex decode table
package seg7_pkg;
  typedef logic [0:6] seg_t;
  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t HEX_SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
endpackage

// File: rtl/hex7seg_decoder.sv
// hex7seg_decoder: combinational hex nibble to a..g segment decode
module hex7seg_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [0:6] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: multiplexed NDIG-digit 7-segment driver with
// leading-zero blanking and per-digit blink
module hex_display_scanner #(
  parameter int NDIG        = 4,
  parameter int PRESCALE    = 50000,
  parameter int BLINK_SCANS = 250
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4*NDIG-1:0] value,
  input  logic              load,
  input  logic              lz_en,
  input  logic [NDIG-1:0]   blink_mask,
  output logic [0:6]        seg,
  output logic [NDIG-1:0]   dig_en
);
  import seg7_pkg::*;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam int SW = BLINK_SCANS > 1 ? $clog2(BLINK_SCANS) : 1;
  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [SW-1:0]     scan_q, scan_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic              phase_q, phase_d;
  seg_t              seg_q, seg_d;
  logic [NDIG-1:0]   dig_q, dig_d;
  logic [3:0]        nib;
  seg_t              dec;
  logic              tick, last, wrap, hi_zero, blank;
  hex7seg_decoder u_dec (.nib(nib), .seg(dec));
  always_comb begin
    tick = pre_q == PW'(PRESCALE - 1);
    last = idx_q == IW'(NDIG - 1);
    wrap = tick && last && scan_q == SW'(BLINK_SCANS - 1);
    nib = shadow_q[4*idx_q +: 4];
    hi_zero = 1'b1;
    for (int j = 0; j < NDIG; j++)
      if (j >= int'(idx_q) && shadow_q[4*j +: 4] != 4'h0) hi_zero = 1'b0;
    blank = (lz_en && hi_zero && idx_q != '0) || (phase_q && blink_mask[idx_q]);
    pre_d = tick ? '0 : pre_q + 1'b1;
    idx_d = tick ? (last ? '0 : idx_q + 1'b1) : idx_q;
    shadow_d = load ? value : shadow_q;
    scan_d = wrap ? '0 : (tick && last) ? scan_q + 1'b1 : scan_q;
    phase_d = phase_q ^ wrap;
    seg_d = tick ? (blank ? SEG_BLANK : dec) : seg_q;
    dig_d = tick ? NDIG'(1) << idx_q : dig_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q    <= '0;
      idx_q    <= '0;
      scan_q   <= '0;
      shadow_q <= '0;
      phase_q  <= 1'b0;
      seg_q    <= SEG_BLANK;
      dig_q    <= '0;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      scan_q   <= scan_d;
      shadow_q <= shadow_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
    end
  end
  assign seg    = seg_q;
  assign dig_en = dig_q;
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: directed checks of scan, blanking, blink and reset
module tb_hex_display_scanner;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [0:6]  seg;
  logic [3:0]  dig_en;
  int          n_checks = 0;
  int          n_fail = 0;
  hex_display_scanner #(.NDIG(4), .PRESCALE(2), .BLINK_SCANS(2)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .lz_en(lz_en),
    .blink_mask(blink_mask), .seg(seg), .dig_en(dig_en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] ed, input logic [6:0] es);
    n_checks++;
    assert ({dig_en, seg} === {ed, es}) else begin
      n_fail++;
      $error("FAIL %s: observed dig_en=%b seg=%b expected dig_en=%b seg=%b", tag, dig_en, seg, ed, es);
    end
  endtask
  task automatic slot(input string tag, input logic [3:0] ed, input logic [6:0] es);
    repeat (2) @(negedge clk);
    chk(tag, ed, es);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_hold", 4'b0000, 7'b0000000);
    reset = 1'b0;
    @(negedge clk);
    chk("first_edge", 4'b0000, 7'b0000000);
    @(negedge clk);
    chk("first_tick", 4'b0001, 7'b1111110);
    value = 16'h12AF; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("scan_d1", 4'b0010, 7'b1110111);
    slot("scan_d2", 4'b0100, 7'b1101101);
    slot("scan_d3", 4'b1000, 7'b0110000);
    slot("scan_d0", 4'b0001, 7'b1000111);
    @(negedge clk);
    chk("scan_hold", 4'b0001, 7'b1000111);
    @(negedge clk);
    chk("scan_wrap_d1", 4'b0010, 7'b1110111);
    value = 16'h0050; load = 1'b1; lz_en = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("lz_d2", 4'b0100, 7'b0000000);
    slot("lz_d3", 4'b1000, 7'b0000000);
    slot("lz_d0", 4'b0001, 7'b1111110);
    slot("lz_d1", 4'b0010, 7'b1011011);
    value = 16'h0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("lz0_d2", 4'b0100, 7'b0000000);
    slot("lz0_d3", 4'b1000, 7'b0000000);
    slot("lz0_d0", 4'b0001, 7'b1111110);
    slot("lz0_d1", 4'b0010, 7'b0000000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; lz_en = 1'b0;
    value = 16'h8888; load = 1'b1; blink_mask = 4'b0010;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("blink_s0_d0", 4'b0001, 7'b1111111);
    for (int s = 0; s < 5; s++)
      for (int d = 0; d < 4; d++)
        if (s != 0 || d != 0)
          slot($sformatf("blink_s%0d_d%0d", s, d), 4'(1 << d),
               (d == 1 && (s == 2 || s == 3)) ? 7'b0000000 : 7'b1111111);
    blink_mask = 4'b0000;
    value = 16'h0003; load = 1'b1;
    @(negedge clk);
    value = 16'h0007;
    @(negedge clk);
    load = 1'b0;
    chk("coinc_old", 4'b0001, 7'b1111001);
    slot("coinc_d1", 4'b0010, 7'b1111110);
    slot("coinc_d2", 4'b0100, 7'b1111110);
    slot("coinc_d3", 4'b1000, 7'b1111110);
    slot("coinc_new", 4'b0001, 7'b1110000);
    slot("mid_d1", 4'b0010, 7'b1111110);
    slot("mid_d2", 4'b0100, 7'b1111110);
    reset = 1'b1;
    #1;
    chk("mid_async", 4'b0000, 7'b0000000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_edge1", 4'b0000, 7'b0000000);
    @(negedge clk);
    chk("mid_restart", 4'b0001, 7'b1111110);
    slot("mid_d1_after", 4'b0010, 7'b1111110);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Time-multiplexed driver for an NDIG-digit common-segment 7-segment display. It latches a packed hex value on a load strobe and scans one digit per prescaler period. Each digit is decoded to a, b, c, d, e, f, g segments, with optional leading-zero blanking and per-digit blinking. It sits between the datapath result registers and the board display pins, replacing per-digit static decoders.

## Interface

Parameters:
- NDIG, 4: number of digits, 1..8.
- PRESCALE, 50000: clock cycles per digit slot, ≥1.
- BLINK_SCANS, 250: full scans per blink half-period, ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- value  in  4*NDIG  packed nibbles; nibble i = digit i, digit 0 least significant.
- load  in  1  when high at a rising edge, value is copied into the shadow register.
- lz_en  in  1  leading-zero blanking enable, sampled every tick.
- blink_mask  in  NDIG  bit i set → digit i blinks.
- seg  out  [0:6]  segments a..g, bit 0 = a, active-high (1 = lit), registered.
- dig_en  out  NDIG  one-hot digit select, active-high, registered.

## Operation

- Shadow register holds the displayed value; only load updates it.
- Prescaler counts 0..PRESCALE-1 and wraps. A tick occurs on the edge where count == PRESCALE-1; PRESCALE=1 ticks every cycle.
- On a tick:
  - seg/dig_en are loaded for digit idx: dig_en = 1<<idx, seg = decode(shadow nibble idx) or blank.
  - idx then increments, wrapping NDIG-1 → 0.
- Decode (a..g), 0..F: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111.
- Blank means seg = 0000000; dig_en is still asserted for that slot.
- Leading-zero blank (lz_en=1): digit i is blank iff nibbles NDIG-1..i are all zero and i ≠ 0. Digit 0 is never LZ-blanked.
- Blink: phase bit, reset 0 = visible.
  - The scan counter (0..BLINK_SCANS-1) increments on each tick that displays digit NDIG-1.
  - At its terminal count it wraps and the phase toggles.
  - Phase 1 blanks digits whose blink_mask bit is set.
- Priority: LZ-blank and blink-blank are OR-ed.

## Timing

- Reset (asynchronous, immediate): prescaler 0, idx 0, shadow 0, blink phase 0, scan counter 0, seg 0000000, dig_en all 0.
- The first non-zero dig_en (digit 0) is visible after the PRESCALE-th rising edge following reset release.
- Each digit is held exactly PRESCALE cycles. A full scan takes NDIG*PRESCALE cycles.
- load latency: the shadow is updated at the same edge. A tick on that same edge still uses the old shadow; the new value appears from the next tick.
- lz_en and blink_mask are sampled at the tick edge only.
- Reset asserted mid-scan clears outputs asynchronously. The scan restarts from digit 0 after release.
- dig_en is never multi-hot. It is all-zero only between reset and the first tick.

## Structure

- Package seg7_pkg:
  - typedef seg_t = logic [0:6].
  - Constant SEG_BLANK = 7'b0000000.
  - Constant array HEX_SEG[16] holding the decode table above.
- Sub-module hex7seg_decoder: combinational, 4-bit nibble → seg_t via seg7_pkg. It is instantiated once on the muxed nibble and is reusable for static displays.
- Counter widths: $clog2 of the range, minimum 1 bit.

## Test plan

All scenarios use NDIG=4, PRESCALE=2, BLINK_SCANS=2.

- **Reset:** hold reset 3 cycles → seg=0000000, dig_en=0000. Release → dig_en=0001 after the 2nd edge, seg=1111110.
- **Normal scan:** load 0x12AF, lz_en=0 → slots 0001:1000111, 0010:1110111, 0100:1101101, 1000:0110000, then wrap to 0001. Each slot lasts 2 cycles.
- **Leading-zero blanking:** load 0x0050, lz_en=1 → digits 3, 2 show 0000000; digit 1 shows 1011011; digit 0 shows 1111110. Load 0x0000 → only digit 0 is lit (1111110).
- **Blink:** load 0x8888, blink_mask=0010 →
  - Digit 1 shows 1111111 in scans 0–1, 0000000 in scans 2–3, and lit again in scan 4.
  - Other digits are always 1111111.
- **Load coincident with tick:** load 0x0007 on the edge that displays digit 0 of old value 0x0003 → that slot shows 1111001; digit 0 shows 1110000 on the next scan.
- **Reset mid-scan:** assert reset while dig_en=0100 → outputs are 0 before the next edge. After release the scan restarts at 0001 and the shadow is 0.
